// File: rtl/key_event_classifier.sv
// Classifies debounced key levels into TAP / LONG / CHORD events and queues them in a show-ahead FIFO.
// Optional auto-repeat while a LONG key is held: define KEY_EVT_AUTO_REPEAT_EN.
module key_event_classifier #(
    parameter int NUM_KEYS   = 12,
    parameter int IDX_W      = 4,
    parameter int CNT_W      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_level,
    input  logic [NUM_KEYS-1:0] imm_mask,
    input  logic [NUM_KEYS-1:0] long_mask,
    input  logic [CNT_W-1:0]    long_threshold,
    input  logic [CNT_W-1:0]    repeat_period,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [2:0]          evt_type,
    output logic [IDX_W-1:0]    evt_key0,
    output logic [IDX_W-1:0]    evt_key1,
    output logic                busy,
    output logic                overflow,
    input  logic                ovf_clr
);

    localparam int unsigned NUM_KEYS_U = NUM_KEYS;
    localparam int unsigned DEPTH_U    = FIFO_DEPTH;
    localparam int          PTR_W      = $clog2(FIFO_DEPTH);
    localparam int          OCC_W      = PTR_W + 1;
    localparam int          PC_W       = $clog2(NUM_KEYS + 1);

    localparam logic [2:0] EVT_TAP    = 3'd0;
    localparam logic [2:0] EVT_LONG   = 3'd1;
    localparam logic [2:0] EVT_CHORD  = 3'd2;
`ifdef KEY_EVT_AUTO_REPEAT_EN
    localparam logic [2:0] EVT_REPEAT = 3'd3;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESSED,
        S_LONG_HELD,
        S_CHORD_HELD,
        S_WAIT_ALL_UP
    } state_t;

    typedef struct packed {
        logic [2:0]       etype;
        logic [IDX_W-1:0] k0;
        logic [IDX_W-1:0] k1;
    } evt_t;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
        logic [IDX_W-1:0] r;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_KEYS_U; i++) begin
            if (v[i] && !found) begin
                r     = IDX_W'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [PC_W-1:0] popcount(input logic [NUM_KEYS-1:0] v);
        logic [PC_W-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < NUM_KEYS_U; i++) begin
            s = s + PC_W'(v[i]);
        end
        return s;
    endfunction

    state_t              state, state_n;
    logic [IDX_W-1:0]    key0, key0_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                push;
    evt_t                push_evt;
    logic [NUM_KEYS-1:0] key0_oh;
    logic [PC_W-1:0]     pc;

    assign key0_oh = NUM_KEYS'(1) << key0;
    assign pc      = popcount(key_level);

`ifdef KEY_EVT_AUTO_REPEAT_EN
    logic [CNT_W-1:0] rp_eff;
    assign rp_eff = (repeat_period == '0) ? CNT_W'(1) : repeat_period;
`else
    logic unused_repeat;
    assign unused_repeat = ^repeat_period;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            key0  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            key0  <= key0_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        key0_n   = key0;
        cnt_n    = cnt;
        push     = 1'b0;
        push_evt = '0;
        case (state)
            S_IDLE: begin
                // With exactly one key down, key_level is one-hot so a mask AND selects that key.
                if (pc == PC_W'(1)) begin
                    if (|(imm_mask & key_level)) begin
                        push     = 1'b1;
                        push_evt = '{EVT_TAP, lowest_idx(key_level), lowest_idx(key_level)};
                        state_n  = S_WAIT_ALL_UP;
                    end else begin
                        key0_n  = lowest_idx(key_level);
                        cnt_n   = CNT_W'(1);
                        state_n = S_PRESSED;
                    end
                end else if (pc >= PC_W'(2)) begin
                    state_n = S_WAIT_ALL_UP;
                end
            end
            S_PRESSED: begin
                if (key_level == '0) begin
                    push     = 1'b1;
                    push_evt = '{EVT_TAP, key0, key0};
                    state_n  = S_IDLE;
                end else if (key_level == key0_oh) begin
                    if (|(long_mask & key0_oh) && cnt >= long_threshold) begin
                        push     = 1'b1;
                        push_evt = '{EVT_LONG, key0, key0};
                        cnt_n    = '0;
                        state_n  = S_LONG_HELD;
                    end else if (cnt != '1) begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end else if (pc == PC_W'(2) && |(key_level & key0_oh)) begin
                    push     = 1'b1;
                    push_evt = '{EVT_CHORD, key0, lowest_idx(key_level & ~key0_oh)};
                    state_n  = S_CHORD_HELD;
                end else begin
                    state_n = S_WAIT_ALL_UP;
                end
            end
            S_LONG_HELD: begin
                if (key_level == '0) begin
                    state_n = S_IDLE;
`ifdef KEY_EVT_AUTO_REPEAT_EN
                end else if (key_level == key0_oh) begin
                    if (cnt >= rp_eff) begin
                        push     = 1'b1;
                        push_evt = '{EVT_REPEAT, key0, key0};
                        cnt_n    = CNT_W'(1);
                    end else if (cnt != '1) begin
                        cnt_n = cnt + CNT_W'(1);
                    end
`endif
                end
            end
            S_CHORD_HELD, S_WAIT_ALL_UP: begin
                if (key_level == '0) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign busy = (state == S_LONG_HELD) || (state == S_CHORD_HELD);

    evt_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [OCC_W-1:0] occ;
    logic             full, pop, accept, drop;

    assign full   = (occ == OCC_W'(FIFO_DEPTH));
    assign pop    = (occ != '0) && evt_ready;
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH_U; i++) begin
                mem[i] <= '0;
            end
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= push_evt;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            // A drop in the same cycle as a clear must still be reported.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign evt_valid = (occ != '0);
    assign evt_type  = mem[rd_ptr].etype;
    assign evt_key0  = mem[rd_ptr].k0;
    assign evt_key1  = mem[rd_ptr].k1;

endmodule
